// File: rtl/ara_pkg.sv
// rtl/ara_pkg.sv - shared vector-unit types and index helpers for the result queue
package ara_pkg;

    localparam int unsigned ELEN    = 64;
    localparam int unsigned VADDR_W = 32;
    localparam int unsigned VID_W   = 3;

    typedef logic [ELEN-1:0]    elen_t;
    typedef logic [ELEN/8-1:0]  strb_t;
    typedef logic [VADDR_W-1:0] vaddr_t;
    typedef logic [VID_W-1:0]   vid_t;

    typedef struct packed {
        elen_t  data;
        vaddr_t addr;
        strb_t  be;
        vid_t   id;
    } result_queue_entry_t;

    // Bits needed to index num_idx values; never less than one bit.
    function automatic int unsigned idx_width(input int unsigned num_idx);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < num_idx) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// rtl/fifo_v3.sv - circular-buffer FIFO with occupancy count, synchronous flush and optional fall-through
module fifo_v3 import ara_pkg::*; #(
    parameter bit           FALL_THROUGH = 1'b0,
    parameter int unsigned  DEPTH        = 2,
    parameter type          dtype        = logic,
    localparam int unsigned AddrW        = idx_width(DEPTH),
    localparam int unsigned CntW         = idx_width(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] usage_o,
    input  dtype            data_i,
    input  logic            push_i,
    output dtype            data_o,
    input  logic            pop_i
);

    dtype             mem_q [DEPTH];
    dtype             mem_d [DEPTH];
    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop, bypass;

    function automatic logic [AddrW-1:0] next_ptr(input logic [AddrW-1:0] ptr);
        return (ptr == AddrW'(DEPTH - 1)) ? '0 : ptr + AddrW'(1);
    endfunction

    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign usage_o = cnt_q;

    always_comb begin
        // In fall-through mode an empty FIFO forwards data_i straight to the head.
        bypass   = FALL_THROUGH && (cnt_q == '0) && push_i;
        do_push  = push_i && !full_o && !flush_i && !(bypass && pop_i);
        do_pop   = pop_i && (cnt_q != '0) && !flush_i;
        empty_o  = (cnt_q == '0) && !bypass;
        data_o   = bypass ? data_i : mem_q[rd_ptr_q];
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CntW'(1);
                2'b01:   cnt_d = cnt_q - CntW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            mem_q    <= '{default: '0};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/vfu_result_queue.sv
// rtl/vfu_result_queue.sv - buffers VFU results and presents them to the VRF write arbiter in order
module vfu_result_queue import ara_pkg::*; #(
    parameter int unsigned  NrLanes      = 0,
    parameter int unsigned  DataBufDepth = 2,
    localparam int unsigned PendW        = idx_width(DataBufDepth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  elen_t            result_i,
    input  vaddr_t           result_addr_i,
    input  strb_t            result_be_i,
    input  vid_t             result_id_i,
    input  logic             result_valid_i,
    output logic             result_ready_o,
    output logic             wbk_req_o,
    output vaddr_t           wbk_addr_o,
    output elen_t            wbk_data_o,
    output strb_t            wbk_be_o,
    output vid_t             wbk_id_o,
    input  logic             wbk_gnt_i,
    output logic             result_final_gnt_o,
    output logic [PendW-1:0] pending_o
);

    result_queue_entry_t push_entry;
    result_queue_entry_t head_entry;
    logic                full, empty, push, pop;
    logic                final_gnt_q, final_gnt_d;

    if (DataBufDepth < 1 || DataBufDepth > 8 || NrLanes > 64) begin : g_param_check
        $error("vfu_result_queue: DataBufDepth must be 1..8 and NrLanes at most 64");
    end

    assign push_entry = '{data: result_i, addr: result_addr_i, be: result_be_i, id: result_id_i};

    // Ready and request derive only from the registered occupancy, never from gnt or valid.
    assign result_ready_o = !full;
    assign wbk_req_o      = !empty;
    assign push           = result_valid_i && result_ready_o;
    assign pop            = wbk_req_o && wbk_gnt_i;

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DEPTH        (DataBufDepth),
        .dtype        (result_queue_entry_t)
    ) i_result_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .full_o  (full),
        .empty_o (empty),
        .usage_o (pending_o),
        .data_i  (push_entry),
        .push_i  (push),
        .data_o  (head_entry),
        .pop_i   (pop)
    );

    assign wbk_addr_o = head_entry.addr;
    assign wbk_data_o = head_entry.data;
    assign wbk_be_o   = head_entry.be;
    assign wbk_id_o   = head_entry.id;

    // A grant landing together with a flush is discarded, so it earns no final grant.
    always_comb begin
        final_gnt_d = pop && !flush_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            final_gnt_q <= 1'b0;
        end else begin
            final_gnt_q <= final_gnt_d;
        end
    end

    assign result_final_gnt_o = final_gnt_q;

endmodule

// File: tb/tb_vfu_result_queue.sv
// tb/tb_vfu_result_queue.sv - scoreboard bench for vfu_result_queue with directed and random traffic
module tb_vfu_result_queue;
    import ara_pkg::*;

    localparam int unsigned Depth = 2;
    localparam int unsigned PW    = idx_width(Depth + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    elen_t         result;
    vaddr_t        addr;
    strb_t         be;
    vid_t          id;
    logic          valid;
    logic          ready;
    logic          wbk_req;
    vaddr_t        wbk_addr;
    elen_t         wbk_data;
    strb_t         wbk_be;
    vid_t          wbk_id;
    logic          gnt;
    logic          final_gnt;
    logic [PW-1:0] pending;

    always #5 clk = ~clk;

    vfu_result_queue #(.NrLanes(0), .DataBufDepth(Depth)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .flush_i            (flush),
        .result_i           (result),
        .result_addr_i      (addr),
        .result_be_i        (be),
        .result_id_i        (id),
        .result_valid_i     (valid),
        .result_ready_o     (ready),
        .wbk_req_o          (wbk_req),
        .wbk_addr_o         (wbk_addr),
        .wbk_data_o         (wbk_data),
        .wbk_be_o           (wbk_be),
        .wbk_id_o           (wbk_id),
        .wbk_gnt_i          (gnt),
        .result_final_gnt_o (final_gnt),
        .pending_o          (pending)
    );

    result_queue_entry_t exp_q[$];
    int n_chk = 0;
    int n_fail = 0;
    int n_pops = 0;
    int n_pulses = 0;
    bit mon_en = 1'b0;
    bit exp_pulse = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the queue holds everything accepted and not yet written, oldest first.
    always @(negedge clk) begin
        if (mon_en) begin
            bit pop_m;
            chk("final_gnt", final_gnt, exp_pulse);
            if (final_gnt) n_pulses++;
            if (!rst_n) begin
                chk("rst_ready", ready, 1);
                chk("rst_req", wbk_req, 0);
                chk("rst_pending", pending, 0);
                exp_q.delete();
                exp_pulse = 1'b0;
            end else begin
                chk("pending", pending, exp_q.size());
                chk("ready", ready, exp_q.size() < Depth);
                chk("req", wbk_req, exp_q.size() != 0);
                if (exp_q.size() != 0) begin
                    chk("wbk_data", wbk_data, exp_q[0].data);
                    chk("wbk_addr", wbk_addr, exp_q[0].addr);
                    chk("wbk_be", wbk_be, exp_q[0].be);
                    chk("wbk_id", wbk_id, exp_q[0].id);
                end
                pop_m = (exp_q.size() != 0) && gnt && !flush;
                if (flush) begin
                    exp_q.delete();
                end else if (pop_m) begin
                    void'(exp_q.pop_front());
                    n_pops++;
                end
                exp_pulse = pop_m;
            end
        end
    end

    // Advance one cycle, recording the offered result if it is accepted.
    task automatic step();
        result_queue_entry_t e;
        @(negedge clk);
        #1;
        if (rst_n && valid && ready && !flush) begin
            e.data = result;
            e.addr = addr;
            e.be   = be;
            e.id   = id;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [63:0] d, input logic [31:0] a);
        valid  = v;
        result = d;
        addr   = a;
        be     = strb_t'($urandom);
        id     = vid_t'($urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        gnt   = 1'b0;
        offer(1'b0, 64'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", ready, 1);
        chk("reset_req", wbk_req, 0);
        chk("reset_pending", pending, 0);
        chk("reset_final_gnt", final_gnt, 0);
        chk("reset_wbk_data", wbk_data, 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Single result with grant held high.
        gnt = 1'b1;
        offer(1'b1, 64'hAAAA, 32'h10);
        step();
        chk("single_req", wbk_req, 1);
        chk("single_data", wbk_data, 64'hAAAA);
        chk("single_addr", wbk_addr, 32'h10);
        offer(1'b0, 64'h0, 32'h0);
        step();
        chk("single_pulse", final_gnt, 1);
        chk("single_pending", pending, 0);
        step();

        // Fill with grant low; third result stalls.
        gnt = 1'b0;
        offer(1'b1, 64'hA, 32'h20);
        step();
        offer(1'b1, 64'hB, 32'h21);
        step();
        chk("full_ready", ready, 0);
        chk("full_pending", pending, 2);
        offer(1'b1, 64'hC, 32'h22);
        step();
        chk("stall_pending", pending, 2);
        // Grant while full and push offered: space appears only next cycle.
        gnt = 1'b1;
        chk("full_gnt_ready", ready, 0);
        step();
        chk("after_pop_ready", ready, 1);
        chk("after_pop_pending", pending, 1);
        gnt = 1'b0;
        step();
        offer(1'b0, 64'h0, 32'h0);
        gnt = 1'b1;
        repeat (4) step();
        chk("drain_pending", pending, 0);

        // Flush with grant high on two entries.
        gnt = 1'b0;
        offer(1'b1, 64'h1111, 32'h30);
        step();
        offer(1'b1, 64'h2222, 32'h31);
        step();
        chk("pre_flush_pending", pending, 2);
        flush = 1'b1;
        gnt   = 1'b1;
        offer(1'b1, 64'h3333, 32'h32);
        step();
        chk("flush_pending", pending, 0);
        chk("flush_req", wbk_req, 0);
        chk("flush_no_pulse", final_gnt, 0);
        flush = 1'b0;
        gnt   = 1'b0;
        offer(1'b0, 64'h0, 32'h0);
        step();
        chk("flush_no_pulse2", final_gnt, 0);

        // Reset mid-stream with one entry.
        offer(1'b1, 64'h5555, 32'h40);
        step();
        offer(1'b0, 64'h0, 32'h0);
        gnt   = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", ready, 1);
        chk("midrst_req", wbk_req, 0);
        chk("midrst_pending", pending, 0);
        chk("midrst_final_gnt", final_gnt, 0);
        chk("midrst_wbk_data", wbk_data, 0);
        chk("midrst_wbk_addr", wbk_addr, 0);
        step();
        rst_n = 1'b1;
        repeat (3) begin
            step();
            chk("post_rst_no_pulse", final_gnt, 0);
        end

        // Random traffic.
        for (int i = 0; i < 10000; i++) begin
            offer($urandom_range(0, 99) < 60, {$urandom, $urandom}, $urandom);
            gnt   = $urandom_range(0, 99) < 50;
            flush = $urandom_range(0, 255) == 0;
            step();
        end
        flush = 1'b0;
        offer(1'b0, 64'h0, 32'h0);
        gnt = 1'b1;
        repeat (Depth + 3) step();
        chk("final_empty", pending, 0);
        mon_en = 1'b0;
        chk("pulse_count", n_pulses, n_pops);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vfu_result_queue.md
VFU_RESULT_QUEUE -- requirements
Module: vfu_result_queue

Interface
REQ-001 SHALL have parameter NrLanes, default 0, number of lanes, used only for width derivation.
REQ-002 SHALL have parameter DataBufDepth, default 2, result entries buffered; legal range 1..8.
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port rst_ni, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port flush_i, input, 1, synchronous discard of all buffered results.
REQ-006 SHALL have port result_i, input, elen_t, VFU result word.
REQ-007 SHALL have port result_addr_i, input, vaddr_t, VRF target address.
REQ-008 SHALL have port result_be_i, input, strb_t, byte enables.
REQ-009 SHALL have port result_id_i, input, vid_t, issuing instruction id.
REQ-010 SHALL have port result_valid_i, input, 1, VFU offers a result.
REQ-011 SHALL have port result_ready_o, output, 1, queue accepts a result.
REQ-012 SHALL have ports wbk_req_o (output, 1), wbk_addr_o (output, vaddr_t), wbk_data_o (output, elen_t), wbk_be_o (output, strb_t), wbk_id_o (output, vid_t), all toward the VRF write arbiter.
REQ-013 SHALL have port wbk_gnt_i, input, 1, arbiter accepted the head write.
REQ-014 SHALL have port result_final_gnt_o, output, 1, one-cycle pulse per committed write, returned to the VFU.
REQ-015 SHALL have port pending_o, output, idx_width(DataBufDepth+1), current occupancy.

Function
REQ-016 SHALL push an entry {data, addr, be, id} on any cycle with result_valid_i and result_ready_o both high.
REQ-017 SHALL drive result_ready_o = !full, registered state only; no combinational path from wbk_gnt_i or result_valid_i.
REQ-018 SHALL assert wbk_req_o exactly when occupancy > 0; wbk_* fields show the head entry (no fall-through: a result pushed in cycle t is requested no earlier than t+1).
REQ-019 SHALL pop the head on any cycle with wbk_req_o and wbk_gnt_i both high; wbk_gnt_i with wbk_req_o low SHALL be ignored.
REQ-020 SHALL pulse result_final_gnt_o in cycle t+1 for every pop in cycle t; pulses SHALL be back-to-back for consecutive pops.
REQ-021 SHALL keep wbk_* fields stable while wbk_req_o is high and wbk_gnt_i is low.
REQ-022 SHALL, on simultaneous push and pop, keep occupancy unchanged and keep FIFO order; when full, no push can occur (ready low), so a pop frees space visible in the next cycle.
REQ-023 SHALL wrap read/write pointers modulo DataBufDepth.
REQ-024 SHALL, on flush_i, set occupancy to 0 next cycle, ignore concurrent push and grant, and suppress result_final_gnt_o in the following cycle.
REQ-025 SHALL maintain pending_o = pushes - pops - flushed entries, saturating never (guaranteed by ready).

Reset
REQ-026 SHALL on rst_ni low clear pointers and occupancy asynchronously: result_ready_o=1, wbk_req_o=0, result_final_gnt_o=0, pending_o=0, wbk_* data fields=0.
REQ-027 SHALL discard in-flight entries on reset mid-operation with no final-grant pulse after release.

Structure
REQ-028 SHALL take elen_t, strb_t, vaddr_t, vid_t from ara_pkg; any new entry struct (result_queue_entry_t) SHALL be added to ara_pkg.
REQ-029 SHALL build storage from one sub-module, fifo_v3 (common_cells), FALL_THROUGH=0, with flush wired to flush_i.

Verification
REQ-030 SHALL cover: push 0xAAAA at addr 0x10, gnt held high -> wbk_req_o rises cycle 1, pop cycle 1, result_final_gnt_o pulse cycle 2, pending_o back to 0.
REQ-031 SHALL cover: depth 2, gnt low, push 3 results -> third stalled (ready_o=0 after 2nd), pending_o=2, order A,B,C on later grants.
REQ-032 SHALL cover: full queue, push offered and gnt in same cycle -> ready_o stays 0 that cycle, 1 next cycle, occupancy 1.
REQ-033 SHALL cover: 2 entries, flush_i with gnt high -> no final-grant pulse, pending_o=0, wbk_req_o=0 next cycle.
REQ-034 SHALL cover: rst_ni pulsed low mid-stream with 1 entry -> all outputs at reset values immediately, no pulse after release.
REQ-035 SHALL cover: random valid/gnt 10k cycles -> scoreboard order, pulse count equals pop count, wbk_* stable under stall.
